// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx -- I2S bus-master transmitter for a PCM5102-class DAC.
//
// Generates scki/bck/lrck from the system clock and serialises one
// left/right sample pair per frame onto dout, MSB first. Upstream logic hands
// pairs over through a valid/ready handshake into a one-entry holding buffer.
// The buffer is drained into the transmit registers at the end of every frame.
// If no pair is waiting, a frame of silence is sent and underrun pulses.
//
// Parameters:
//   DATA_W  : sample width in bits (1..SLOT_W-1; up to SLOT_W in LJ mode)
//   SLOT_W  : bck periods per channel slot (frame = 2*SLOT_W bck periods)
//   BCK_DIV : clk cycles per bck period (even, >= 2)
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   left_in   in   left sample, two's complement
//   right_in  in   right sample, two's complement
//   valid_in  in   pair on left_in/right_in is valid
//   ready_out out  holding buffer empty (forced low during reset)
//   underrun  out  one-cycle pulse when a frame starts with the buffer empty
//   scki      out  DAC system clock, pass-through of clk
//   bck       out  bit clock, registered
//   lrck      out  word select, registered (0 = left, 1 = right)
//   dout      out  serial data, registered, MSB first
//
// Build option:
//   I2S_TX_LJ_EN : when defined, left-justified format (MSB in the same bck
//                  period as the lrck transition). Otherwise standard I2S
//                  with a one-bck delay.
// -----------------------------------------------------------------------------
module i2s_tx #(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] left_in,
    input  logic signed [DATA_W-1:0] right_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic                     underrun,
    output logic                     scki,
    output logic                     bck,
    output logic                     lrck,
    output logic                     dout
);

    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int BIT_W = (SLOT_W > 0) ? $clog2(2 * SLOT_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_W);

    // Bit of sample s that belongs at slot position p, or 0 outside the
    // data field of the slot.
    function automatic logic slot_bit(input logic signed [DATA_W-1:0] s,
                                      input int p);
        logic [DATA_W-1:0] sh;
        int                idx;
`ifdef I2S_TX_LJ_EN
        idx = DATA_W - 1 - p;
`else
        idx = DATA_W - p;
`endif
        slot_bit = 1'b0;
        sh       = s;
        if (idx >= 0 && idx < DATA_W) begin
            sh       = sh >> idx;
            slot_bit = sh[0];
        end
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic signed [DATA_W-1:0] left_sr_q, left_sr_d;
    logic signed [DATA_W-1:0] right_sr_q, right_sr_d;
    logic signed [DATA_W-1:0] buf_l_q, buf_l_d;
    logic signed [DATA_W-1:0] buf_r_q, buf_r_d;
    logic buf_full_q, buf_full_d;
    logic bck_q, bck_d;
    logic lrck_q, lrck_d;
    logic dout_q, dout_d;

    logic div_wrap;
    logic frame_load;
    logic accept;
    int   slot_pos;

    assign div_wrap   = (div_cnt_q == DIV_LAST);
    assign frame_load = div_wrap && (bit_cnt_q == BIT_LAST);
    assign ready_out  = !buf_full_q && !reset;
    assign accept     = valid_in && ready_out;
    assign underrun   = frame_load && !buf_full_q && !reset;

    assign scki = clk;
    assign bck  = bck_q;
    assign lrck = lrck_q;
    assign dout = dout_q;

    always_comb begin
        div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        buf_full_d = buf_full_q;
        dout_d     = dout_q;

        if (div_wrap) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end

        // End of frame: the load sees the buffer as it was before any
        // same-cycle accept, so a pair accepted here waits one more frame.
        if (frame_load) begin
            if (buf_full_q) begin
                left_sr_d  = buf_l_q;
                right_sr_d = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
                left_sr_d  = '0;
                right_sr_d = '0;
            end
        end

        if (accept) begin
            buf_l_d    = left_in;
            buf_r_d    = right_in;
            buf_full_d = 1'b1;
        end

        // Outputs are registered from next-state values so bck/lrck/dout
        // line up with the counters in the same cycle.
        bck_d  = (div_cnt_d >= DIV_HALF);
        lrck_d = (bit_cnt_d >= RIGHT_FIRST);

        slot_pos = lrck_d ? int'(bit_cnt_d) - SLOT_W : int'(bit_cnt_d);

        // The transmit registers are held static and indexed by slot
        // position; dout only moves on the bck falling edge (div wrap).
        if (div_wrap) begin
            dout_d = slot_bit(lrck_d ? right_sr_d : left_sr_d, slot_pos);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            left_sr_q  <= '0;
            right_sr_q <= '0;
            buf_full_q <= 1'b0;
            bck_q      <= 1'b0;
            lrck_q     <= 1'b0;
            dout_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;
            buf_full_q <= buf_full_d;
            bck_q      <= bck_d;
            lrck_q     <= lrck_d;
            dout_q     <= dout_d;
        end
    end

    // Buffer contents are qualified by buf_full_q, so they need no reset.
    always_ff @(posedge clk) begin
        buf_l_q <= buf_l_d;
        buf_r_q <= buf_r_d;
    end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

    localparam int DATA_W  = 24;
    localparam int SLOT_W  = 32;
    localparam int BCK_DIV = 4;
    localparam int NBIT    = 2 * SLOT_W;
    localparam int FRAME   = NBIT * BCK_DIV;
`ifdef I2S_TX_LJ_EN
    localparam int SLOT_SH = SLOT_W - DATA_W;
`else
    localparam int SLOT_SH = SLOT_W - 1 - DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] left_in = '0;
    logic [DATA_W-1:0] right_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_out, underrun, scki, bck, lrck, dout;

    i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCK_DIV(BCK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .left_in  (left_in),
        .right_in (right_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .underrun (underrun),
        .scki     (scki),
        .bck      (bck),
        .lrck     (lrck),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                frame;
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rst_q;
    int   last_acc_cyc = -1;
    int   last_acc_frame = 0;

    // Period index since reset release: period 0 is the first with reset low.
    always @(posedge clk) begin
        rst_q <= reset;
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Whole frame as transmitted MSB first: left slot then right slot, each
    // slot being the sample placed inside a field of zeros.
    function automatic logic [NBIT-1:0] frame_bits(input logic [DATA_W-1:0] l,
                                                   input logic [DATA_W-1:0] r);
        logic [SLOT_W-1:0] sl, sr;
        sl = SLOT_W'(l) << SLOT_SH;
        sr = SLOT_W'(r) << SLOT_SH;
        return {sl, sr};
    endfunction

    function automatic bit frame_queued(input int f);
        foreach (sb_q[i]) if (sb_q[i].frame == f) return 1'b1;
        return 1'b0;
    endfunction

    // A pair accepted in period c is consumed by the first load strictly
    // after c and plays in the frame following that load.
    task automatic record(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        exp_t e;
        e.frame = (cyc + 1) / FRAME + 1;
        e.l = l;
        e.r = r;
        sb_q.push_back(e);
        last_acc_cyc   = cyc;
        last_acc_frame = e.frame;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int n = 0;
        bit done = 0;
        left_in  = l;
        right_in = r;
        valid_in = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready_out && !reset) begin
                done = 1;
                record(l, r);
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 2 * FRAME) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout cyc=%0d got=no_accept expected=accept", cyc);
                done = 1;
            end
        end
        valid_in = 1'b0;
    endtask

    // Monitor: checks clocks/handshake every cycle and decodes each frame.
    logic            prev_bck = 1'b0;
    logic            prev_dout = 1'b0;
    logic [NBIT-1:0] cap = '0;
    int              ncap = 0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("ready_in_reset", 64'(ready_out), 64'd0);
            if (rst_q === 1'b1)
                check("outputs_in_reset", 64'({bck, lrck, dout, underrun}), 64'd0);
            prev_bck  = 1'b0;
            prev_dout = 1'b0;
            ncap      = 0;
        end else begin
            bit full;
            bit exp_u;
            full = (last_acc_cyc >= 0) && (last_acc_cyc < cyc) &&
                   (cyc <= FRAME * last_acc_frame - 1);
            exp_u = ((cyc % FRAME) == FRAME - 1) && !frame_queued(cyc / FRAME + 1);
            check("bck", 64'(bck), 64'((cyc % BCK_DIV) >= BCK_DIV / 2));
            check("lrck", 64'(lrck), 64'((cyc % FRAME) >= FRAME / 2));
            check("ready", 64'(ready_out), 64'(!full));
            check("underrun", 64'(underrun), 64'(exp_u));
            if (dout !== prev_dout)
                check("dout_edge", 64'({prev_bck, bck}), 64'b10);
            if (bck && !prev_bck) begin
                int pos;
                pos = (cyc % FRAME) / BCK_DIV;
                cap[NBIT-1-pos] = dout;
                ncap++;
                if (pos == NBIT - 1) begin
                    int              f;
                    logic [NBIT-1:0] exp_f;
                    exp_t            e;
                    f = cyc / FRAME;
                    while (sb_q.size() > 0 && sb_q[0].frame < f) begin
                        checks++;
                        failures++;
                        $display("FAIL unplayed_pair cyc=%0d got=frame%0d expected=frame%0d",
                                 cyc, f, sb_q[0].frame);
                        void'(sb_q.pop_front());
                    end
                    if (sb_q.size() > 0 && sb_q[0].frame == f) begin
                        e = sb_q.pop_front();
                        exp_f = frame_bits(e.l, e.r);
                    end else begin
                        exp_f = frame_bits('0, '0);
                    end
                    check("bits_per_frame", 64'(ncap), 64'(NBIT));
                    check("frame_data", cap, exp_f);
                    ncap = 0;
                end
            end
            prev_bck  = bck;
            prev_dout = dout;
        end
    end

    // Stimulus
    initial begin
        int prev_f;
        int guard;
        int target;
        logic [DATA_W-1:0] base;

        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle frame: silence, underrun at the first load.
        wait_cycles(FRAME + 20);

        // Directed pairs.
        send(24'hA5F00F, 24'h5A0FF0);
        wait_cycles(2 * FRAME);
        send(24'h800001, 24'h7FFFFE);

        // Continuous stream: one accept per frame.
        base = DATA_W'($urandom);
        for (int i = 0; i < 8; i++) begin
            prev_f = last_acc_frame;
            send(base + DATA_W'(i), ~(base + DATA_W'(i)));
            if (i > 0) check("accept_rate", 64'(last_acc_frame - prev_f), 64'd1);
        end

        // One frame without data, then resume.
        wait_cycles(FRAME + FRAME / 2);
        for (int i = 0; i < 3; i++) send(DATA_W'($urandom), DATA_W'($urandom));
        wait_cycles(2 * FRAME);

        // Random pairs with random gaps.
        for (int i = 0; i < 6; i++) begin
            send(DATA_W'($urandom), DATA_W'($urandom));
            wait_cycles($urandom_range(0, 300));
        end
        wait_cycles(2 * FRAME);

        // Reset in the middle of a frame with a pair buffered.
        send(DATA_W'($urandom), DATA_W'($urandom));
        target = (last_acc_frame) * FRAME + 40 * BCK_DIV;
        send(DATA_W'($urandom), DATA_W'($urandom));
        guard = 0;
        while (cyc != target && guard < 3 * FRAME) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != target) begin
            checks++;
            failures++;
            $display("FAIL reset_point_timeout cyc=%0d got=%0d expected=%0d", cyc, cyc, target);
        end
        reset = 1'b1;
        sb_q.delete();
        last_acc_cyc = -1;
        wait_cycles(3);
        reset = 1'b0;

        wait_cycles(FRAME + 10);
        send(DATA_W'($urandom), DATA_W'($urandom));
        wait_cycles(2 * FRAME + 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S transmitter: the output direction of the audio path, sending processed samples to an external DAC (PCM5102-class).
- Sits beside the existing i2s receiver on the same system clock (~11.9 MHz).
- As bus master it generates scki, bck and lrck, and serializes left/right sample pairs onto dout.
- Upstream logic supplies sample pairs through a valid/ready handshake into a one-entry holding buffer.

Parameters:
- DATA_W, 24: sample width in bits. Legal range is 1..SLOT_W-1.
- SLOT_W, 32: bck periods per channel slot. A frame is 2*SLOT_W bck periods.
- BCK_DIV, 4: clk cycles per bck period. Must be even and >=2. One frame = 2*SLOT_W*BCK_DIV clk cycles (default 256, so fs = clk/256).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- left_in  in  DATA_W  left sample, two's complement
- right_in  in  DATA_W  right sample, two's complement
- valid_in  in  1  sample pair on left_in/right_in is valid
- ready_out  out  1  holding buffer empty; pair accepted when valid_in & ready_out
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty
- scki  out  1  DAC system clock, direct pass-through of clk (not reset-gated)
- bck  out  1  bit clock, registered
- lrck  out  1  word select, registered; 0 = left slot, 1 = right slot
- dout  out  1  serial data, registered, MSB first

Behaviour:
- Single clock: clk, synchronous active-high reset. All state updates on the clk rising edge.
- While reset is high:
  - div_cnt=0, bit_cnt=0; shift registers cleared; buffer empty.
  - bck=0, lrck=0, dout=0, underrun=0, ready_out=0.
- ready_out = !buf_full, except it is forced to 0 while reset is high. It is first 1 in the first cycle after reset deasserts.
- Reset asserted mid-frame: immediate return to the reset state; any buffered sample is discarded.
- div_cnt counts 0..BCK_DIV-1 and wraps.
  - bck is 1 while div_cnt >= BCK_DIV/2, else 0, registered so it matches div_cnt in the same cycle.
  - The bck falling edge coincides with the div_cnt wrap to 0.
- bit_cnt counts 0..2*SLOT_W-1 and increments at each div_cnt wrap.
  - lrck = (bit_cnt >= SLOT_W), updated together with bit_cnt.
- Slot position p = bit_cnt mod SLOT_W. The active sample is the left shift register when lrck=0, the right one when lrck=1.
  - Standard I2S (one-bck delay): dout = sample[DATA_W-p] for p in 1..DATA_W, else 0.
  - dout changes only on bck falling edges and is stable across each rising edge.
- Frame load occurs in the cycle where div_cnt==BCK_DIV-1 and bit_cnt==2*SLOT_W-1.
  - Buffer full: the shift registers load the buffer contents and buf_full clears.
  - Buffer empty: the shift registers load zeros (silence) and underrun pulses high for exactly that cycle.
- Accept occurs when valid_in & ready_out: the pair is written to the buffer and buf_full sets next cycle.
  - Accept and frame load in the same cycle: the load uses the pre-accept buffer state (no bypass). The accepted pair plays in the following frame.
- After reset, the first frame transmits zeros. Its end-of-frame load, in cycle 2*SLOT_W*BCK_DIV-1 counted from the first cycle after reset, consumes the first accepted pair.
- Signed values pass through unmodified; no saturation or rounding.

Optional Feature:
- Macro: I2S_TX_LJ_EN.
- Defined: left-justified format, with no one-bck delay. dout = sample[DATA_W-1-p] for p in 0..DATA_W-1, else 0. The MSB is output in the same bck period as the lrck transition. DATA_W == SLOT_W becomes legal.
- Undefined: standard I2S timing as described in Behaviour.

Test Plan:
- Reset held 10 cycles, then released with valid_in=0 -> all outputs 0 during reset. Afterwards bck has period 4 clk (high on div_cnt 2,3), lrck has period 256 clk, and dout stays 0.
- One pair accepted, left=24'hA5F00F, right=24'h5A0FF0 -> ready_out drops for the remainder of frame 1. In frame 2, the bit sampled on each bck rising edge (from bck period 1 to 24) reproduces 0xA5F00F MSB first with lrck=0. The right channel reproduces 0x5A0FF0 in bck periods 33-56. All other slot bits are 0.
- Continuous valid_in with incrementing samples -> exactly one accept per 256 clk and no underrun pulses. The decoded stream equals the input sequence, shifted by one frame.
- valid_in dropped for one frame -> underrun pulses for 1 cycle at the load point, that frame is all zeros, and normal output resumes the frame after.
- Reset asserted at bit_cnt=40 -> outputs 0 in the next cycle and the buffered pair is lost. After release, the timing restarts from bit_cnt=0.
- With I2S_TX_LJ_EN defined, left=24'h800001 -> dout=1 in bck period 0 (lrck=0), dout=1 in period 23, and 0 elsewhere in the slot.
